// File: rtl/rv_go_hazard_ctrl_if.sv
// Interface: rv_go_hazard_ctrl_if
// D/E-stage hazard inputs and the stall/flush/forward controls of rv_go_hazard_ctrl.
// master = core pipeline side, slave = hazard controller.
interface rv_go_hazard_ctrl_if #(
    parameter int unsigned STALL_CNT_W = 16
);
    logic                   d_valid;
    logic [4:0]             d_rs1;
    logic [4:0]             d_rs2;
    logic                   d_use_rs1;
    logic                   d_use_rs2;
    logic [4:0]             d_rd;
    logic                   d_reg_w;
    logic                   d_mem_to_reg;
    logic                   e_redirect;
    logic                   stall_f;
    logic                   stall_d;
    logic                   flush_d;
    logic                   flush_e;
    logic [1:0]             fwd_a;
    logic [1:0]             fwd_b;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_reg_w,
               d_mem_to_reg, e_redirect,
        input  stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_reg_w,
               d_mem_to_reg, e_redirect,
        output stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/rv_go_hazard_ctrl.sv
// Module: rv_go_hazard_ctrl
// Pipeline sequencer for the 5-stage rv_go core: shadows the writers in E/M/W,
// generates F/D stalls, D/E flushes and E-stage operand forward selects.
// Optional feature macro: RV_GO_FWD_EN (defined = operand forwarding with
// load-use stall FSM; undefined = stall until the writer retires).
module rv_go_hazard_ctrl #(
    parameter int unsigned STALL_CNT_W = 16,
    parameter int unsigned RF_BYPASS   = 1
) (
    input logic                clk,
    input logic                rst,
    rv_go_hazard_ctrl_if.slave hz
);
    localparam int unsigned REG_W = 5;

    // A writer is reduced to "really writes a non-zero rd" plus the rd itself.
    typedef struct packed {
        logic             wr;
        logic [REG_W-1:0] rd;
    } writer_t;

    writer_t                d_writer;
    writer_t                e_writer;
    writer_t                m_writer;
    writer_t                w_writer;
    logic                   d_use1;
    logic                   d_use2;
    logic                   d_hit_e;
    logic                   d_hit_m;
    logic                   d_hit_w;
    logic                   w_haz;
    logic                   stall_req;
    logic                   stall;
    logic                   flush_e;
    logic [1:0]             fwd_a_raw;
    logic [1:0]             fwd_b_raw;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    function automatic logic hit(writer_t w, logic en, logic [REG_W-1:0] rs);
        return w.wr & en & (w.rd == rs);
    endfunction

    // Qualify the D instruction and match its sources against each writer.
    always_comb begin
        d_writer.wr = hz.d_valid & hz.d_reg_w & (hz.d_rd != '0);
        d_writer.rd = hz.d_rd;
        d_use1      = hz.d_valid & hz.d_use_rs1;
        d_use2      = hz.d_valid & hz.d_use_rs2;
        d_hit_e     = hit(e_writer, d_use1, hz.d_rs1) | hit(e_writer, d_use2, hz.d_rs2);
        d_hit_m     = hit(m_writer, d_use1, hz.d_rs1) | hit(m_writer, d_use2, hz.d_rs2);
        d_hit_w     = hit(w_writer, d_use1, hz.d_rs1) | hit(w_writer, d_use2, hz.d_rs2);
        w_haz       = (RF_BYPASS == 0) && d_hit_w;
    end

`ifdef RV_GO_FWD_EN
    typedef enum logic {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } state_t;

    state_t           state;
    logic             load_use;
    logic             e_load;
    logic             e_use1;
    logic             e_use2;
    logic [REG_W-1:0] e_rs1;
    logic [REG_W-1:0] e_rs2;

    // Load-use detection and E operand select; M wins over W.
    always_comb begin
        load_use  = e_load & d_hit_e;
        stall_req = load_use | w_haz;
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (hit(m_writer, e_use1, e_rs1)) begin
            fwd_a_raw = 2'b10;
        end else if (hit(w_writer, e_use1, e_rs1)) begin
            fwd_a_raw = 2'b01;
        end
        if (hit(m_writer, e_use2, e_rs2)) begin
            fwd_b_raw = 2'b10;
        end else if (hit(w_writer, e_use2, e_rs2)) begin
            fwd_b_raw = 2'b01;
        end
    end

    // Load-use FSM and E-stage source shadow; a redirect always returns to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            e_load <= 1'b0;
            e_use1 <= 1'b0;
            e_use2 <= 1'b0;
            e_rs1  <= '0;
            e_rs2  <= '0;
        end else begin
            case (state)
                RUN:     state <= (load_use && !hz.e_redirect) ? LDSTALL : RUN;
                // E holds the bubble while the load sits in M; a fresh hazard re-enters.
                LDSTALL: state <= (load_use && !hz.e_redirect) ? LDSTALL : RUN;
                default: state <= RUN;
            endcase
            e_load <= ~flush_e & hz.d_valid & hz.d_mem_to_reg;
            e_use1 <= ~flush_e & d_use1;
            e_use2 <= ~flush_e & d_use2;
            e_rs1  <= hz.d_rs1;
            e_rs2  <= hz.d_rs2;
        end
    end
`else
    logic unused_load;

    // Without forwarding, D waits until no in-flight writer matches it.
    always_comb begin
        stall_req   = d_hit_e | d_hit_m | w_haz;
        fwd_a_raw   = 2'b00;
        fwd_b_raw   = 2'b00;
        unused_load = hz.d_mem_to_reg;
    end
`endif

    // A redirect overrides any stall and squashes both D and E.
    always_comb begin
        stall   = stall_req & ~hz.e_redirect;
        flush_e = stall | hz.e_redirect;
    end

    // Writer shadow pipeline and saturating stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_writer    <= '0;
            m_writer    <= '0;
            w_writer    <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_writer <= flush_e ? '0 : d_writer;
            m_writer <= e_writer;
            w_writer <= m_writer;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
        end
    end

    // Controls are forced quiet while reset is asserted.
    always_comb begin
        hz.stall_f   = rst & stall;
        hz.stall_d   = rst & stall;
        hz.flush_d   = rst & hz.e_redirect;
        hz.flush_e   = rst & flush_e;
        hz.fwd_a     = rst ? fwd_a_raw : 2'b00;
        hz.fwd_b     = rst ? fwd_b_raw : 2'b00;
        hz.stall_cnt = stall_cnt_q;
    end
endmodule

// File: tb/tb_rv_go_hazard_ctrl.sv
// Testbench: tb_rv_go_hazard_ctrl
// Scoreboarded bench for rv_go_hazard_ctrl with an instruction-level pipeline model.
// Follows RV_GO_FWD_EN the same way as the design.
module tb_rv_go_hazard_ctrl;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;
    localparam bit          RFB  = 1'b1;
`ifdef RV_GO_FWD_EN
    localparam int EXP_A = 0, EXP_B = 0, EXP_C = 1;
`else
    localparam int EXP_A = 2, EXP_B = 1, EXP_C = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    rv_go_hazard_ctrl_if #(.STALL_CNT_W(CW)) hz ();
    rv_go_hazard_ctrl #(.STALL_CNT_W(CW), .RF_BYPASS(1)) dut (.clk(clk), .rst(rst), .hz(hz));

    always #5 clk = ~clk;

    typedef struct { bit v, wr, ld, u1, u2; bit [4:0] rs1, rs2, rd; } ins_t;
    typedef struct { bit sf, sd, fd, fe; bit [1:0] fa, fb; int cnt; } exp_t;

    exp_t exp_q[$];
    ins_t pipe[3];          // 0 = E, 1 = M, 2 = W
    int   cnt_m;
    bit   last_stall;
    int   checks;
    int   errors;

    function automatic ins_t mk(bit v, bit wr, bit ld, bit u1, bit u2,
                                bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2);
        ins_t i;
        i.v = v; i.wr = wr; i.ld = ld; i.u1 = u1; i.u2 = u2;
        i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        return i;
    endfunction
    function automatic ins_t bubble();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic ins_t rr(bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2);
        return mk(1, 1, 0, 1, 1, rd, rs1, rs2);
    endfunction
    function automatic ins_t lw(bit [4:0] rd, bit [4:0] rs1);
        return mk(1, 1, 1, 1, 0, rd, rs1, 0);
    endfunction
    function automatic ins_t addi(bit [4:0] rd, bit [4:0] rs1);
        return mk(1, 1, 0, 1, 0, rd, rs1, 0);
    endfunction
    function automatic ins_t nop();
        return addi(0, 0);
    endfunction
    function automatic ins_t rand_ins();
        return mk($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    endfunction

    // Writer w produces a value the reader needs through source rs.
    function automatic bit wm(ins_t w, bit u, bit [4:0] rs);
        return w.v && w.wr && (w.rd != 0) && u && (w.rd == rs);
    endfunction
    function automatic bit d_hits(ins_t w, ins_t d);
        return wm(w, d.u1, d.rs1) || wm(w, d.u2, d.rs2);
    endfunction
    function automatic bit [1:0] fsel(bit u, bit [4:0] rs);
        if (wm(pipe[1], u, rs)) return 2'b10;
        if (wm(pipe[2], u, rs)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = bubble();
        cnt_m = 0;
        last_stall = 1'b0;
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive D/E at posedge+1, queue the expected controls, advance the model.
    task automatic step(ins_t d, bit redir);
        exp_t e;
        bit   stall;
        ins_t q;
        hz.d_valid = d.v; hz.d_rs1 = d.rs1; hz.d_rs2 = d.rs2;
        hz.d_use_rs1 = d.u1; hz.d_use_rs2 = d.u2; hz.d_rd = d.rd;
        hz.d_reg_w = d.wr; hz.d_mem_to_reg = d.ld; hz.e_redirect = redir;
        q = d;
        q.wr = d.v & d.wr; q.ld = d.v & d.ld; q.u1 = d.v & d.u1; q.u2 = d.v & d.u2;
        e = '{default: 0};
        stall = 1'b0;
        if (rst) begin
`ifdef RV_GO_FWD_EN
            stall = (pipe[0].ld && d_hits(pipe[0], q)) || (!RFB && d_hits(pipe[2], q));
            e.fa = fsel(pipe[0].u1, pipe[0].rs1);
            e.fb = fsel(pipe[0].u2, pipe[0].rs2);
            if (pipe[1].ld && (wm(pipe[1], pipe[0].u1, pipe[0].rs1) ||
                               wm(pipe[1], pipe[0].u2, pipe[0].rs2))) begin
                checks++;
                errors++;
                $display("FAIL ld_in_m: load in M feeds E, got match expected none at %0t", $time);
            end
`else
            stall = d_hits(pipe[0], q) || d_hits(pipe[1], q) || (!RFB && d_hits(pipe[2], q));
`endif
            if (redir) stall = 1'b0;
            e.sf = stall; e.sd = stall; e.fd = redir; e.fe = stall | redir;
            e.cnt = cnt_m;
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            if (stall && cnt_m < CMAX) cnt_m++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (stall || redir) ? bubble() : q;
            last_stall = stall;
        end else begin
            model_reset();
        end
        #1;
    endtask

    // Hold an instruction in D until the pipeline accepts it.
    task automatic issue(ins_t d, bit redir);
        int n;
        n = 0;
        do begin
            step(d, redir);
            n++;
        end while (last_stall && n < 8);
        if (last_stall) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got stall after %0d cycles expected release", n);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) issue(nop(), 1'b0);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        step(nop(), 1'b0);
        rst = 1'b1;
    endtask

    // Assert reset between edges and expect the controls to drop at once.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        hz.e_redirect = 1'b1;
        #1;
        check("rst_stall_f", int'(hz.stall_f), 0);
        check("rst_stall_d", int'(hz.stall_d), 0);
        check("rst_flush_d", int'(hz.flush_d), 0);
        check("rst_flush_e", int'(hz.flush_e), 0);
        check("rst_fwd_a", int'(hz.fwd_a), 0);
        check("rst_fwd_b", int'(hz.fwd_b), 0);
        check("rst_stall_cnt", int'(hz.stall_cnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        step(nop(), 1'b1);
        rst = 1'b1;
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall_f", int'(hz.stall_f), int'(e.sf));
            check("stall_d", int'(hz.stall_d), int'(e.sd));
            check("flush_d", int'(hz.flush_d), int'(e.fd));
            check("flush_e", int'(hz.flush_e), int'(e.fe));
            check("fwd_a", int'(hz.fwd_a), int'(e.fa));
            check("fwd_b", int'(hz.fwd_b), int'(e.fb));
            check("stall_cnt", int'(hz.stall_cnt), e.cnt);
        end
    end

    initial begin
        ins_t cur;
        bit   redir;
        checks = 0;
        errors = 0;
        hz.d_valid = 0; hz.d_rs1 = 0; hz.d_rs2 = 0; hz.d_use_rs1 = 0; hz.d_use_rs2 = 0;
        hz.d_rd = 0; hz.d_reg_w = 0; hz.d_mem_to_reg = 0; hz.e_redirect = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset_dut();

        // add x5,x1,x2; add x6,x5,x5
        issue(rr(5, 1, 2), 0); issue(rr(6, 5, 5), 0); drain();
        check("seq_back2back_cnt", int'(hz.stall_cnt), EXP_A);
        reset_dut();

        // add x5; nop; sub x7,x5,x3
        issue(rr(5, 1, 2), 0); issue(nop(), 0); issue(rr(7, 5, 3), 0); drain();
        check("seq_gap1_cnt", int'(hz.stall_cnt), EXP_B);
        reset_dut();

        // lw x5,0(x1); add x6,x5,x0
        issue(lw(5, 1), 0); issue(rr(6, 5, 0), 0); drain();
        check("seq_load_use_cnt", int'(hz.stall_cnt), EXP_C);
        reset_dut();

        // lw x5 in E redirecting while add x6,x5 sits in D
        issue(lw(5, 1), 0); issue(rr(6, 5, 0), 1); drain();
        check("seq_redirect_cnt", int'(hz.stall_cnt), 0);
        reset_dut();

        // addi x0,x0,1; add x1,x0,x0
        issue(addi(0, 0), 0); issue(rr(1, 0, 0), 0); drain();
        check("seq_x0_cnt", int'(hz.stall_cnt), 0);

        // Repeated load-use hazards drive the counter into saturation.
        for (int i = 0; i < 20; i++) begin
            issue(lw(5, 1), 0);
            issue(rr(6, 5, 0), 0);
        end
        drain();
        check("stall_cnt_saturate", int'(hz.stall_cnt), CMAX);

        // Reset in the middle of a stall.
        issue(lw(5, 1), 0);
        step(rr(6, 5, 0), 0);
        mid_reset();

        // Randomized traffic over a small register set.
        cur = nop();
        for (int c = 0; c < 400; c++) begin
            if (!last_stall) cur = rand_ins();
            redir = ($urandom_range(0, 15) == 0);
            step(cur, redir);
        end
        drain();

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
